// File: rtl/prim_subreg_pkg.sv
// prim_subreg_pkg: shared types and helpers for register slices.
// Holds access modes, shadow phase enum and the sw_arb function.
package prim_subreg_pkg;

  typedef enum logic [2:0] {
    SwAccessRW,
    SwAccessWO,
    SwAccessRO,
    SwAccessW1C,
    SwAccessW1S,
    SwAccessW0C,
    SwAccessRC
  } sw_access_e;

  typedef enum logic {
    ShPhase0,
    ShPhase1
  } shadow_phase_e;

  localparam int unsigned MaxDW = 32;

  // Software effect on a base value; narrower callers
  // zero-extend and take the low bits.
  function automatic logic [MaxDW-1:0] sw_arb(
    input sw_access_e       mode,
    input logic [MaxDW-1:0] cur,
    input logic [MaxDW-1:0] wd
  );
    logic [MaxDW-1:0] r;
    r = cur;
    unique case (mode)
      SwAccessRW:  r = wd;
      SwAccessWO:  r = wd;
      SwAccessW1C: r = cur & ~wd;
      SwAccessW1S: r = cur | wd;
      SwAccessW0C: r = cur & wd;
      SwAccessRC:  r = '0;
      default:     r = cur;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/prim_subreg_arb.sv
// prim_subreg_arb: next-value arbitration between sw and hw writes.
// Ports: cur (current), en_sw/wd (sw), de/d (hw), nxt (result).
module prim_subreg_arb
  import prim_subreg_pkg::*;
#(
  parameter int unsigned DW       = 32,
  parameter sw_access_e  SwAccess = SwAccessRW
) (
  input  logic [DW-1:0] cur,
  input  logic          en_sw,
  input  logic [DW-1:0] wd,
  input  logic          de,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] nxt
);

  logic [DW-1:0]    hw;
  logic [MaxDW-1:0] sw;
  logic             unused_sw;

  // Hardware value forms the base; software
  // modifies it, so RW/WO data wins outright.
  assign hw = de ? d : cur;

  assign sw = sw_arb(SwAccess,
                     MaxDW'(hw),
                     MaxDW'(wd));

  assign nxt = en_sw ? sw[DW-1:0] : hw;

  assign unused_sw = ^sw;

endmodule

// File: rtl/prim_subreg_shadow.sv
// prim_subreg_shadow: two-write shadowed CSR slice with inverted copy.
// Ports: clk_i, rst_i (sync, high), re/we/wd (sw), de/d (hw),
//   qe/q/qs (committed), phase_o, err_update, err_storage.
// Macro PRIM_SUBREG_SHADOW_LOCK_EN freezes the slice once
//   err_storage is set.
module prim_subreg_shadow
  import prim_subreg_pkg::*;
#(
  parameter int unsigned   DW       = 32,
  parameter sw_access_e    SwAccess = SwAccessRW,
  parameter logic [DW-1:0] RESVAL   = '0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          re,
  input  logic          we,
  input  logic [DW-1:0] wd,
  input  logic          de,
  input  logic [DW-1:0] d,
  output logic          qe,
  output logic [DW-1:0] q,
  output logic [DW-1:0] qs,
  output logic          phase_o,
  output logic          err_update,
  output logic          err_storage
);

  localparam bit FsmEn = (SwAccess != SwAccessRO);

  shadow_phase_e phase, phase_nxt;

  logic [DW-1:0] committed;
  logic [DW-1:0] shadow;
  logic [DW-1:0] staged;
  logic [DW-1:0] stage_nxt;
  logic [DW-1:0] commit_nxt;

  logic locked;
  logic in_p1;
  logic match;
  logic load;
  logic commit;
  logic mism;
  logic upd;

`ifdef PRIM_SUBREG_SHADOW_LOCK_EN
  assign locked = err_storage;
`else
  assign locked = 1'b0;
`endif

  // Software-only candidate: what the staged copy
  // holds and what the second write must reproduce.
  prim_subreg_arb #(
    .DW       (DW),
    .SwAccess (SwAccess)
  ) u_stage_arb (
    .cur   (committed),
    .en_sw (1'b1),
    .wd    (wd),
    .de    (1'b0),
    .d     (d),
    .nxt   (stage_nxt)
  );

  prim_subreg_arb #(
    .DW       (DW),
    .SwAccess (SwAccess)
  ) u_commit_arb (
    .cur   (committed),
    .en_sw (commit),
    .wd    (wd),
    .de    (de),
    .d     (d),
    .nxt   (commit_nxt)
  );

  assign in_p1  = (phase == ShPhase1);
  assign match  = (stage_nxt == staged);

  assign load   = FsmEn && we && !in_p1
                  && !locked;
  assign commit = FsmEn && we && in_p1
                  && match && !locked;
  assign mism   = FsmEn && we && in_p1
                  && !match && !locked;
  assign upd    = (commit || de) && !locked;

  // re drops back to the first phase, but a
  // same-cycle we is still honoured first.
  always_comb begin
    phase_nxt = phase;
    if (!FsmEn || locked) begin
      phase_nxt = ShPhase0;
    end else if (re) begin
      phase_nxt = ShPhase0;
    end else if (we) begin
      phase_nxt = in_p1 ? ShPhase0 : ShPhase1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      committed   <= RESVAL;
      shadow      <= ~RESVAL;
      staged      <= RESVAL;
      phase       <= ShPhase0;
      qe          <= 1'b0;
      err_update  <= 1'b0;
      err_storage <= 1'b0;
    end else begin
      if (upd) begin
        committed <= commit_nxt;
        shadow    <= ~commit_nxt;
      end
      if (load) begin
        staged <= stage_nxt;
      end
      phase       <= phase_nxt;
      qe          <= commit;
      err_update  <= mism;
      err_storage <= err_storage
                     | (committed != ~shadow);
    end
  end

  assign q       = committed;
  assign qs      = committed;
  assign phase_o = (phase == ShPhase1);

endmodule

// File: tb/tb_prim_subreg_shadow.sv
// tb_prim_subreg_shadow: directed + random bench for the shadow slice.
// Runs an RW and a W1C instance against a reference model.
module tb_prim_subreg_shadow;
  import prim_subreg_pkg::*;

`ifdef PRIM_SUBREG_SHADOW_LOCK_EN
  localparam bit LockEn = 1'b1;
`else
  localparam bit LockEn = 1'b0;
`endif

  localparam logic [7:0] RV = 8'h5A;

  logic       clk = 1'b0;
  logic       rst, re, we, de;
  logic [7:0] wd, d;

  logic [7:0] q_s[2];
  logic [7:0] qs_s[2];
  logic       qe_s[2];
  logic       ph_s[2];
  logic       eu_s[2];
  logic       es_s[2];

  logic [7:0] m_com[2];
  logic [7:0] m_stg[2];
  logic       m_ph[2];
  logic       m_qe[2];
  logic       m_eu[2];
  logic       m_es[2];

  int         md[2] = '{0, 3};
  int         checks = 0;
  int         errors = 0;
  logic [7:0] fshadow;

  always #5 clk = ~clk;

  prim_subreg_shadow #(
    .DW(8), .SwAccess(SwAccessRW), .RESVAL(RV)
  ) u_rw (
    .clk_i(clk), .rst_i(rst), .re(re), .we(we),
    .wd(wd), .de(de), .d(d),
    .qe(qe_s[0]), .q(q_s[0]), .qs(qs_s[0]),
    .phase_o(ph_s[0]), .err_update(eu_s[0]),
    .err_storage(es_s[0])
  );

  prim_subreg_shadow #(
    .DW(8), .SwAccess(SwAccessW1C), .RESVAL(RV)
  ) u_wc (
    .clk_i(clk), .rst_i(rst), .re(re), .we(we),
    .wd(wd), .de(de), .d(d),
    .qe(qe_s[1]), .q(q_s[1]), .qs(qs_s[1]),
    .phase_o(ph_s[1]), .err_update(eu_s[1]),
    .err_storage(es_s[1])
  );

  // Spec rule: hw data (if de) is the base, then sw acts on it.
  function automatic logic [7:0] ref_arb(
    input int m, input logic [7:0] cur,
    input bit sw, input logic [7:0] w,
    input bit h, input logic [7:0] hd);
    logic [7:0] base;
    base = h ? hd : cur;
    if (!sw) return base;
    if (m == 0) return w;
    if (m == 3) return base & ~w;
    return base;
  endfunction

  task automatic chk(input string tag, input int i,
                     input logic [7:0] o,
                     input logic [7:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s[%0d] observed %h expected %h",
             tag, i, o, e);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk("q", i, q_s[i], m_com[i]);
      chk("qs", i, qs_s[i], m_com[i]);
      chk("qe", i, 8'(qe_s[i]), 8'(m_qe[i]));
      chk("phase", i, 8'(ph_s[i]), 8'(m_ph[i]));
      chk("err_upd", i, 8'(eu_s[i]), 8'(m_eu[i]));
      chk("err_sto", i, 8'(es_s[i]), 8'(m_es[i]));
    end
    chk("staged", 0, u_rw.staged, m_stg[0]);
    chk("staged", 1, u_wc.staged, m_stg[1]);
  endtask

  task automatic tick(input bit flip);
    logic [7:0] nc[2], ns[2];
    logic       np[2], nq[2], nu[2], ne[2];
    for (int i = 0; i < 2; i++) begin
      bit lk, cm, mm;
      logic [7:0] sv;
      lk = LockEn && m_es[i];
      sv = ref_arb(md[i], m_com[i], 1'b1, wd, 1'b0, 8'h00);
      cm = 1'b0;
      mm = 1'b0;
      nc[i] = m_com[i];
      ns[i] = m_stg[i];
      if (rst) begin
        nc[i] = RV; ns[i] = RV; np[i] = 1'b0;
        nq[i] = 1'b0; nu[i] = 1'b0; ne[i] = 1'b0;
      end else begin
        if (we && !lk) begin
          if (!m_ph[i]) ns[i] = sv;
          else if (sv == m_stg[i]) cm = 1'b1;
          else mm = 1'b1;
        end
        if (!lk && (cm || de))
          nc[i] = ref_arb(md[i], m_com[i], cm, wd, de, d);
        np[i] = !lk && !re && (we ? !m_ph[i] : m_ph[i]);
        nq[i] = cm;
        nu[i] = mm;
        ne[i] = m_es[i] | (flip && i == 0);
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      m_com[i] = nc[i]; m_stg[i] = ns[i]; m_ph[i] = np[i];
      m_qe[i] = nq[i]; m_eu[i] = nu[i]; m_es[i] = ne[i];
    end
    check_all();
  endtask

  task automatic idle();
    rst = 0; re = 0; we = 0; de = 0; wd = 0; d = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick(1'b0);
    rst = 0;
  endtask

  initial begin
    logic [7:0] lastwd;
    for (int i = 0; i < 2; i++) begin
      m_com[i] = 'x; m_stg[i] = 'x; m_ph[i] = 'x;
      m_qe[i] = 'x; m_eu[i] = 'x; m_es[i] = 'x;
    end
    idle();
    #1;
    do_reset();
    chk("rst_q", 0, q_s[0], 8'h5A);
    chk("rst_ph", 0, 8'(ph_s[0]), 8'h00);
    chk("rst_err", 0, {6'd0, eu_s[0], es_s[0]}, 8'h00);

    // Matching double write commits.
    we = 1; wd = 8'h33; tick(1'b0);
    chk("p1_after_w1", 0, 8'(ph_s[0]), 8'h01);
    tick(1'b0);
    chk("commit_q", 0, q_s[0], 8'h33);
    chk("commit_qe", 0, 8'(qe_s[0]), 8'h01);
    chk("commit_ph", 0, 8'(ph_s[0]), 8'h00);
    we = 0; tick(1'b0);
    chk("qe_drop", 0, 8'(qe_s[0]), 8'h00);

    // Mismatched second write.
    do_reset();
    we = 1; wd = 8'h33; tick(1'b0);
    wd = 8'h34; tick(1'b0);
    chk("mism_eu", 0, 8'(eu_s[0]), 8'h01);
    chk("mism_q", 0, q_s[0], 8'h5A);
    we = 0; tick(1'b0);
    chk("mism_eu_drop", 0, 8'(eu_s[0]), 8'h00);

    // W1C with and without a concurrent hw write.
    do_reset();
    de = 1; d = 8'hFF; tick(1'b0);
    de = 0;
    chk("w1c_hw", 1, q_s[1], 8'hFF);
    we = 1; wd = 8'h0F; tick(1'b0);
    tick(1'b0);
    chk("w1c_q", 1, q_s[1], 8'hF0);
    we = 0; tick(1'b0);
    we = 1; tick(1'b0);
    de = 1; d = 8'h81; tick(1'b0);
    chk("w1c_de_q", 1, q_s[1], 8'h80);
    idle(); tick(1'b0);

    // re abandons a pending first write.
    do_reset();
    we = 1; wd = 8'h11; tick(1'b0);
    we = 0; re = 1; tick(1'b0);
    re = 0; we = 1; wd = 8'h22; tick(1'b0);
    chk("re_ph", 0, 8'(ph_s[0]), 8'h01);
    chk("re_stg", 0, u_rw.staged, 8'h22);
    chk("re_q", 0, q_s[0], 8'h5A);
    we = 0;
    rst = 1; tick(1'b0);
    rst = 0;
    chk("midrst_stg", 0, u_rw.staged, 8'h5A);
    chk("midrst_ph", 0, 8'(ph_s[0]), 8'h00);

    // Random traffic against the model.
    lastwd = 8'h00;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 60) == 0);
      we  = $urandom_range(0, 1) == 1;
      re  = ($urandom_range(0, 5) == 0);
      de  = ($urandom_range(0, 3) == 0);
      d   = 8'($urandom);
      if ($urandom_range(0, 1) == 1)
        wd = lastwd;
      else
        wd = 8'($urandom_range(0, 255));
      lastwd = wd;
      tick(1'b0);
    end

    // Storage fault on the RW shadow copy.
    do_reset();
    fshadow = ~m_com[0] ^ 8'h01;
    force u_rw.shadow = fshadow;
    tick(1'b1);
    release u_rw.shadow;
    chk("sto_set", 0, 8'(es_s[0]), 8'h01);
    tick(1'b0);
    chk("sto_sticky", 0, 8'(es_s[0]), 8'h01);
    we = 1; wd = 8'h44; tick(1'b0);
    tick(1'b0);
    we = 0; tick(1'b0);
    chk("sto_q", 0, q_s[0], LockEn ? 8'h5A : 8'h44);
    chk("sto_hold", 0, 8'(es_s[0]), 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
